// File: rtl/usr_pkg.sv
// Shared op codes and FSM state encodings for univ_shift_reg.
package usr_pkg;

   localparam logic [2:0] OP_HOLD   = 3'b000;
   localparam logic [2:0] OP_LOAD   = 3'b001;
   localparam logic [2:0] OP_SHL    = 3'b010;
   localparam logic [2:0] OP_SHR    = 3'b011;
   localparam logic [2:0] OP_CLEAR  = 3'b100;
   localparam logic [2:0] OP_ROTATE = 3'b101;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ROT  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/univ_shift_reg_dff_r_en_w.sv
// WIDTH-bit D flip-flop bank with synchronous active-high reset and enable.
module univ_shift_reg_dff_r_en_w #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with load/shift/clear and an optional multi-cycle
// rotate engine compiled in by UNIV_SHIFT_REG_ROTATE_EN.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar,
   output logic             so,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] op_result;
   logic             q_en;

   univ_shift_reg_dff_r_en_w #(.WIDTH(WIDTH)) u_dff (
      .clk   (clk),
      .reset (reset),
      .en    (q_en),
      .d     (q_next),
      .q     (q)
   );

   assign q_bar = ~q;
   assign so    = q[WIDTH-1];

   // ROTATE is not handled here; it is driven by the FSM below (or held).
   always_comb begin
      op_result = q;
      case (op)
         OP_LOAD:  op_result = d;
         OP_SHL:   op_result = {q[WIDTH-2:0], si};
         OP_SHR:   op_result = {si, q[WIDTH-1:1]};
         OP_CLEAR: op_result = '0;
         default:  op_result = q;
      endcase
   end

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   logic [1:0]       state, state_next;
   logic [AMT_W-1:0] count, count_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // FIN behaves like IDLE for accepting ops, so back-to-back rotates work.
   always_comb begin
      state_next = state;
      count_next = count;
      q_next     = op_result;
      q_en       = 1'b0;
      case (state)
         ST_ROT: begin
            q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
            q_en       = 1'b1;
            count_next = count - AMT_W'(1);
            if (count == AMT_W'(1))
               state_next = ST_FIN;
         end
         default: begin
            state_next = ST_IDLE;
            if (en) begin
               q_en = 1'b1;
               if (op == OP_ROTATE) begin
                  count_next = amt;
                  state_next = (amt == '0) ? ST_FIN : ST_ROT;
               end
            end
         end
      endcase
   end

   assign busy = (state == ST_ROT);
   assign done = (state == ST_FIN);
`else
   logic unused_amt;

   assign unused_amt = ^amt;
   assign q_next     = op_result;
   assign q_en       = en;
   assign busy       = 1'b0;
   assign done       = 1'b0;
`endif

endmodule
